// File: rtl/tropical_pkg.sv
// Shared decode definitions for the tropical operand-fetch stage.
// R-type field layout, legal opcode/func values and the canonical infinity.
package tropical_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] FUNC_AND  = 6'd0;
    localparam logic [5:0] FUNC_OR   = 6'd1;
    localparam logic [5:0] FUNC_TADD = 6'd2;
    localparam logic [5:0] FUNC_TMUL = 6'd4;

    localparam logic [31:0] INF_CANON = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] func;
    } instr_t;

    function automatic logic is_legal(input instr_t ins);
        return (ins.op == OP_RTYPE) &&
               ((ins.func == FUNC_AND) || (ins.func == FUNC_OR) ||
                (ins.func == FUNC_TADD) || (ins.func == FUNC_TMUL));
    endfunction

endpackage

// File: rtl/tropical_regfile.sv
// 32-entry register file, two async read ports, one canonicalizing write port.
// Every entry resets to tropical infinity (all ones).
module tropical_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rd_addr1_i,
    output logic [DATA_W-1:0] rd_data1_o,
    input  logic [4:0]        rd_addr2_i,
    output logic [DATA_W-1:0] rd_data2_o,
    input  logic              wr_en_i,
    input  logic [4:0]        wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] wr_canon_o
);

    // Any value carrying the infinity flag collapses to the single all-ones encoding.
    function automatic logic [DATA_W-1:0] canon(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? {DATA_W{1'b1}} : v;
    endfunction

    logic [DATA_W-1:0] regs_q [32];

    assign wr_canon_o = canon(wr_data_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= {DATA_W{1'b1}};
            end
        end else if (wr_en_i) begin
            regs_q[wr_addr_i] <= wr_canon_o;
        end
    end

    assign rd_data1_o = regs_q[rd_addr1_i];
    assign rd_data2_o = regs_q[rd_addr2_i];

endmodule

// File: rtl/tropical_operand_fetch.sv
// Decode / operand-fetch stage feeding the tropical ALU: scoreboarded hazard
// check, writeback forwarding and a single registered issue slot.
module tropical_operand_fetch
    import tropical_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr_code,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [5:0]        alu_func,
    output logic [4:0]        alu_rd,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              illegal_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  illegal_cnt
);

    instr_t dec;
    logic   legal;
    logic   unused_shamt;

    assign dec          = instr_t'(instr_code);
    assign legal        = is_legal(dec);
    assign unused_shamt = ^dec.shamt;

    logic [31:0] pend_q, pend_d, wb_clr, pend_eff;
    logic        hazard, accept, issue, drop;

    always_comb begin
        wb_clr = '0;
        if (wb_valid) wb_clr[wb_rd] = 1'b1;
    end

    // A pending bit cleared by this cycle's writeback no longer blocks.
    assign pend_eff = pend_q & ~wb_clr;
    assign hazard   = legal && (pend_eff[dec.rs] || pend_eff[dec.rt] || pend_eff[dec.rd]);

    logic alu_valid_q, alu_valid_d;

    assign instr_ready = (!alu_valid_q || alu_ready) && !hazard;
    assign accept      = instr_valid && instr_ready;
    assign issue       = accept && legal;
    assign drop        = accept && !legal;

    logic [DATA_W-1:0] rf_rd1, rf_rd2, wb_canon, opa, opb;

    tropical_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .rd_addr1_i (dec.rs),
        .rd_data1_o (rf_rd1),
        .rd_addr2_i (dec.rt),
        .rd_data2_o (rf_rd2),
        .wr_en_i    (wb_valid),
        .wr_addr_i  (wb_rd),
        .wr_data_i  (wb_data),
        .wr_canon_o (wb_canon)
    );

    assign opa = (wb_valid && (wb_rd == dec.rs)) ? wb_canon : rf_rd1;
    assign opb = (wb_valid && (wb_rd == dec.rt)) ? wb_canon : rf_rd2;

    logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d;
    logic [5:0]        func_q, func_d;
    logic [4:0]        rd_q, rd_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_q, stall_d, ill_q, ill_d;

    always_comb begin
        alu_valid_d = alu_valid_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        func_d      = func_q;
        rd_d        = rd_q;
        pend_d      = pend_eff;
        err_d       = err_q;
        stall_d     = stall_q;
        ill_d       = ill_q;

        if (issue) begin
            alu_valid_d    = 1'b1;
            in1_d          = opa;
            in2_d          = opb;
            func_d         = dec.func;
            rd_d           = dec.rd;
            // Set after the writeback clear so a same-cycle issue to wb_rd stays pending.
            pend_d[dec.rd] = 1'b1;
        end else if (alu_valid_q && alu_ready) begin
            alu_valid_d = 1'b0;
        end

        if (drop) begin
            err_d = 1'b1;
            if (ill_q != {CNT_W{1'b1}}) ill_d = ill_q + CNT_W'(1);
        end

        if (instr_valid && !instr_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_valid_q <= 1'b0;
            in1_q       <= '0;
            in2_q       <= '0;
            func_q      <= '0;
            rd_q        <= '0;
            pend_q      <= '0;
            err_q       <= 1'b0;
            stall_q     <= '0;
            ill_q       <= '0;
        end else begin
            alu_valid_q <= alu_valid_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            func_q      <= func_d;
            rd_q        <= rd_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
            ill_q       <= ill_d;
        end
    end

    assign alu_valid   = alu_valid_q;
    assign alu_in1     = in1_q;
    assign alu_in2     = in2_q;
    assign alu_func    = func_q;
    assign alu_rd      = rd_q;
    assign illegal_err = err_q;
    assign stall_cnt   = stall_q;
    assign illegal_cnt = ill_q;

endmodule

// File: tb/tb_tropical_operand_fetch.sv
// Directed bench for tropical_operand_fetch: a cycle-by-cycle vector table
// plus short hand sequences for counters and reset in mid-operation.
module tb_tropical_operand_fetch;

    localparam logic [31:0] F = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_code;
    logic        alu_valid;
    logic        alu_ready;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [5:0]  alu_func;
    logic [4:0]  alu_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal_err;
    logic [15:0] stall_cnt;
    logic [15:0] illegal_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tropical_operand_fetch #(.DATA_W(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_code  (instr_code),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_func    (alu_func),
        .alu_rd      (alu_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .illegal_err (illegal_err),
        .stall_cnt   (stall_cnt),
        .illegal_cnt (illegal_cnt)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [31:0] code;
        logic        ar;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        ex_ready;
        logic        ex_av;
        logic        chk_data;
        logic [31:0] ex_in1;
        logic [31:0] ex_in2;
        logic [5:0]  ex_func;
        logic [4:0]  ex_rd;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic v, input logic [31:0] code,
                                input logic ar, input logic wbv, input logic [4:0] wbrd,
                                input logic [31:0] wbd, input logic er, input logic eav,
                                input logic cd, input logic [31:0] e1, input logic [31:0] e2,
                                input logic [5:0] ef, input logic [4:0] erd);
        vec_t t;
        t.r = r; t.v = v; t.code = code; t.ar = ar; t.wbv = wbv; t.wbrd = wbrd; t.wbd = wbd;
        t.ex_ready = er; t.ex_av = eav; t.chk_data = cd;
        t.ex_in1 = e1; t.ex_in2 = e2; t.ex_func = ef; t.ex_rd = erd;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t t);
        @(negedge clk);
        rst         = t.r;
        instr_valid = t.v;
        instr_code  = t.code;
        alu_ready   = t.ar;
        wb_valid    = t.wbv;
        wb_rd       = t.wbrd;
        wb_data     = t.wbd;
        #1;
        check($sformatf("step%0d instr_ready", idx), {31'b0, instr_ready}, {31'b0, t.ex_ready});
        @(posedge clk);
        #1;
        check($sformatf("step%0d alu_valid", idx), {31'b0, alu_valid}, {31'b0, t.ex_av});
        if (t.chk_data) begin
            check($sformatf("step%0d alu_in1", idx), alu_in1, t.ex_in1);
            check($sformatf("step%0d alu_in2", idx), alu_in2, t.ex_in2);
            check($sformatf("step%0d alu_func", idx), {26'b0, alu_func}, {26'b0, t.ex_func});
            check($sformatf("step%0d alu_rd", idx), {27'b0, alu_rd}, {27'b0, t.ex_rd});
        end
    endtask

    vec_t tbl[$];
    vec_t hand[$];

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_code = '0; alu_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

        //               r  v  code          ar wbv rd     data           rdy av cd in1           in2           fn rd
        tbl.push_back(mk(0, 1, 32'h00220002, 1, 0, 5'd0,  32'h0,          1, 1, 1, F,            F,            2, 0));
        tbl.push_back(mk(0, 1, 32'h00001001, 1, 0, 5'd0,  32'h0,          0, 0, 0, 0,            0,            0, 0));
        tbl.push_back(mk(0, 1, 32'h00001001, 1, 0, 5'd0,  32'h0,          0, 0, 0, 0,            0,            0, 0));
        tbl.push_back(mk(0, 1, 32'h00001001, 1, 1, 5'd0,  32'h80000000,   1, 1, 1, F,            F,            1, 2));
        tbl.push_back(mk(0, 0, 32'h00000000, 1, 1, 5'd3,  32'h7FFFFFFF,   1, 0, 0, 0,            0,            0, 0));
        tbl.push_back(mk(0, 0, 32'h00000000, 1, 1, 5'd4,  32'h00000001,   1, 0, 0, 0,            0,            0, 0));
        tbl.push_back(mk(0, 1, 32'h00642804, 1, 0, 5'd0,  32'h0,          1, 1, 1, 32'h7FFFFFFF, 32'h1,        4, 5));
        tbl.push_back(mk(0, 1, 32'h00643004, 1, 1, 5'd4,  32'h00000005,   1, 1, 1, 32'h7FFFFFFF, 32'h5,        4, 6));
        tbl.push_back(mk(0, 1, 32'h00E74000, 0, 0, 5'd0,  32'h0,          0, 1, 1, 32'h7FFFFFFF, 32'h5,        4, 6));
        tbl.push_back(mk(0, 1, 32'h00E74000, 0, 0, 5'd0,  32'h0,          0, 1, 1, 32'h7FFFFFFF, 32'h5,        4, 6));
        tbl.push_back(mk(0, 1, 32'h00E74000, 0, 0, 5'd0,  32'h0,          0, 1, 1, 32'h7FFFFFFF, 32'h5,        4, 6));
        tbl.push_back(mk(0, 1, 32'h00E74000, 1, 0, 5'd0,  32'h0,          1, 1, 1, F,            F,            0, 8));
        tbl.push_back(mk(0, 1, 32'h00000003, 1, 0, 5'd0,  32'h0,          1, 0, 0, 0,            0,            0, 0));
        tbl.push_back(mk(0, 1, 32'h04000000, 1, 0, 5'd0,  32'h0,          1, 0, 0, 0,            0,            0, 0));
        tbl.push_back(mk(0, 1, 32'h00221802, 1, 1, 5'd2,  32'h00000010,   1, 1, 1, F,            32'h10,       2, 3));
        tbl.push_back(mk(0, 1, 32'h00004801, 1, 1, 5'd9,  32'h00000042,   1, 1, 1, F,            F,            1, 9));
        tbl.push_back(mk(0, 1, 32'h01205000, 1, 0, 5'd0,  32'h0,          0, 0, 0, 0,            0,            0, 0));
        tbl.push_back(mk(0, 1, 32'h01205000, 1, 1, 5'd11, 32'h80001234,   0, 0, 0, 0,            0,            0, 0));
        tbl.push_back(mk(0, 0, 32'h00000000, 1, 1, 5'd9,  32'h00000077,   1, 0, 0, 0,            0,            0, 0));
        tbl.push_back(mk(0, 1, 32'h012B6004, 1, 0, 5'd0,  32'h0,          1, 1, 1, 32'h77,       F,            4, 12));

        // Mid-operation reset: R7 written and then pending with an instruction in the slot.
        hand.push_back(mk(0, 0, 32'h00000000, 1, 1, 5'd7,  32'h00000123,  1, 0, 0, 0,            0,            0, 0));
        hand.push_back(mk(0, 1, 32'h00003800, 0, 0, 5'd0,  32'h0,         1, 1, 1, F,            F,            0, 7));
        hand.push_back(mk(1, 0, 32'h00000000, 0, 1, 5'd5,  32'h00000055,  0, 0, 1, 0,            0,            0, 0));
        hand.push_back(mk(0, 1, 32'h00E53801, 1, 0, 5'd0,  32'h0,         1, 1, 1, F,            F,            1, 7));

        repeat (3) @(posedge clk);
        #1;
        check("reset alu_valid", {31'b0, alu_valid}, 32'h0);
        check("reset alu_in1", alu_in1, 32'h0);
        check("reset alu_in2", alu_in2, 32'h0);
        check("reset alu_func_rd", {21'b0, alu_func, alu_rd}, 32'h0);
        check("reset illegal_err", {31'b0, illegal_err}, 32'h0);
        check("reset counters", {stall_cnt, illegal_cnt}, 32'h0);

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        check("stall_cnt", {16'b0, stall_cnt}, 32'd7);
        check("illegal_cnt", {16'b0, illegal_cnt}, 32'd2);
        check("illegal_err sticky", {31'b0, illegal_err}, 32'h1);

        apply(100, hand[0]);
        apply(101, hand[1]);
        apply(102, hand[2]);
        check("post-rst illegal_err", {31'b0, illegal_err}, 32'h0);
        check("post-rst counters", {stall_cnt, illegal_cnt}, 32'h0);
        apply(103, hand[3]);

        @(negedge clk);
        instr_valid = 1'b0; wb_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
